// File: rtl/mtr_pkg.sv
// Shared constants and types for the meter counter bank: word selects,
// CTL bit positions and the per-channel qualification mode.
package mtr_pkg;

    localparam int unsigned MTR_DATA_W = 36;

    localparam int unsigned MTR_SEL_CTL    = 0;
    localparam int unsigned MTR_SEL_PERIOD = 1;
    localparam int unsigned MTR_SEL_COUNT  = 2;
    localparam int unsigned MTR_SEL_CH0    = 3;

    localparam int unsigned MTR_CTL_PIA_LSB  = 0;
    localparam int unsigned MTR_CTL_PIA_W    = 3;
    localparam int unsigned MTR_CTL_TBE      = 3;
    localparam int unsigned MTR_CTL_IE       = 4;
    localparam int unsigned MTR_CTL_OIE      = 5;
    localparam int unsigned MTR_CTL_DONE     = 7;
    localparam int unsigned MTR_CTL_MODE_LSB = 8;
    localparam int unsigned MTR_CTL_OVF_LSB  = 24;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        ALWAYS = 2'b01,
        USER   = 2'b10,
        EXEC   = 2'b11
    } mtr_mode_t;

endpackage

// File: rtl/mtr_chan_counter.sv
// One accounting channel: mode-qualified event counter with CPU load and a
// sticky overflow flag (write-1-to-clear, set wins over clear).
module mtr_chan_counter
    import mtr_pkg::*;
#(
    parameter int unsigned CNT_W = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  mtr_mode_t        mode,
    input  logic             user_mode,
    input  logic             ev,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_data,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             qual;
    logic             ovf_set;

    always_comb begin
        qual    = 1'b0;
        ovf_set = 1'b0;
        cnt_d   = cnt_q;
        case (mode)
            OFF:     qual = 1'b0;
            ALWAYS:  qual = ev;
            USER:    qual = ev & user_mode;
            EXEC:    qual = ev & ~user_mode;
            default: qual = 1'b0;
        endcase
        // CPU load takes precedence over a coincident increment
        if (ld) begin
            cnt_d = ld_data;
        end else if (qual) begin
            cnt_d   = cnt_q + CNT_W'(1);
            ovf_set = &cnt_q;
        end
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/mtr_counter_bank.sv
// Meter counter bank: prescaled time base, programmable interval timer and
// NCHAN accounting counters behind a word-select read/write port.
module mtr_counter_bank
    import mtr_pkg::*;
#(
    parameter int unsigned NCHAN    = 4,
    parameter int unsigned CNT_W    = 36,
    parameter int unsigned INTVL_W  = 12,
    parameter int unsigned TICK_DIV = 25,
    parameter int unsigned SEL_W    = $clog2(NCHAN + 3)
) (
    input  logic                  clk_mtr_h,
    input  logic                  mr_reset_h,
    input  logic                  user_mode_h,
    input  logic [NCHAN-1:0]      ev_h,
    input  logic                  wr_stb_h,
    input  logic                  rd_stb_h,
    input  logic [SEL_W-1:0]      sel_h,
    input  logic [MTR_DATA_W-1:0] wr_data_h,
    output logic [MTR_DATA_W-1:0] rd_data_h,
    output logic                  rd_valid_h,
    output logic                  tick_h,
    output logic [2:0]            mtr_pia_h,
    output logic                  mtr_interrupt_req_h
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [2:0]            pia_q, pia_d;
    logic                  tbe_q, tbe_d;
    logic                  ie_q, ie_d;
    logic                  oie_q, oie_d;
    logic                  done_q, done_d;
    mtr_mode_t             mode_q [NCHAN];
    mtr_mode_t             mode_d [NCHAN];
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [INTVL_W-1:0]    period_q, period_d;
    logic [INTVL_W-1:0]    count_q, count_d;
    logic [MTR_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  irq_q, irq_d;

    logic [CNT_W-1:0]      cnt [NCHAN];
    logic [NCHAN-1:0]      ovf;
    logic                  wr_ctl, wr_period, wr_count;
    logic                  done_set;
    logic [MTR_DATA_W-1:0] ctl_word;
    logic                  unused_wr_bits;

    assign wr_ctl    = wr_stb_h && (sel_h == SEL_W'(MTR_SEL_CTL));
    assign wr_period = wr_stb_h && (sel_h == SEL_W'(MTR_SEL_PERIOD));
    assign wr_count  = wr_stb_h && (sel_h == SEL_W'(MTR_SEL_COUNT));
    assign unused_wr_bits = ^wr_data_h;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        mtr_chan_counter #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk_mtr_h),
            .rst       (mr_reset_h),
            .mode      (mode_q[g]),
            .user_mode (user_mode_h),
            .ev        (ev_h[g]),
            .ld        (wr_stb_h && (sel_h == SEL_W'(MTR_SEL_CH0 + g))),
            .ld_data   (wr_data_h[CNT_W-1:0]),
            .ovf_clr   (wr_ctl && wr_data_h[MTR_CTL_OVF_LSB + g]),
            .cnt       (cnt[g]),
            .ovf       (ovf[g])
        );
    end

    always_comb begin
        pia_d      = pia_q;
        tbe_d      = tbe_q;
        ie_d       = ie_q;
        oie_d      = oie_q;
        mode_d     = mode_q;
        presc_d    = '0;
        tick_d     = 1'b0;
        done_set   = 1'b0;
        count_d    = count_q;
        period_d   = period_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_stb_h;
        ctl_word   = '0;

        if (wr_ctl) begin
            pia_d = wr_data_h[MTR_CTL_PIA_LSB +: MTR_CTL_PIA_W];
            tbe_d = wr_data_h[MTR_CTL_TBE];
            ie_d  = wr_data_h[MTR_CTL_IE];
            oie_d = wr_data_h[MTR_CTL_OIE];
            for (int i = 0; i < NCHAN; i++) begin
                mode_d[i] = mtr_mode_t'(wr_data_h[MTR_CTL_MODE_LSB + 2*i +: 2]);
            end
        end

        // Time base wraps after TICK_DIV cycles and emits one tick per wrap
        if (tbe_q) begin
            if (presc_q == PRE_W'(TICK_DIV - 1)) begin
                tick_d = 1'b1;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end

        if (ie_q && tick_q) begin
            if ((period_q != '0) && (count_q == period_q - INTVL_W'(1))) begin
                count_d  = '0;
                done_set = 1'b1;
            end else begin
                count_d = count_q + INTVL_W'(1);
            end
        end
        if (wr_count) begin
            count_d = wr_data_h[INTVL_W-1:0];
        end
        if (wr_period) begin
            period_d = wr_data_h[INTVL_W-1:0];
        end
        done_d = (done_q & ~(wr_ctl & wr_data_h[MTR_CTL_DONE])) | done_set;

        irq_d = (pia_q != 3'd0) && (done_q || (oie_q && (|ovf)));

        // Read snapshot uses pre-write state
        ctl_word[MTR_CTL_PIA_LSB +: MTR_CTL_PIA_W] = pia_q;
        ctl_word[MTR_CTL_TBE]  = tbe_q;
        ctl_word[MTR_CTL_IE]   = ie_q;
        ctl_word[MTR_CTL_OIE]  = oie_q;
        ctl_word[MTR_CTL_DONE] = done_q;
        for (int i = 0; i < NCHAN; i++) begin
            ctl_word[MTR_CTL_MODE_LSB + 2*i +: 2] = mode_q[i];
            ctl_word[MTR_CTL_OVF_LSB + i]         = ovf[i];
        end

        if (rd_stb_h) begin
            rd_data_d = '0;
            if (sel_h == SEL_W'(MTR_SEL_CTL))    rd_data_d = ctl_word;
            if (sel_h == SEL_W'(MTR_SEL_PERIOD)) rd_data_d = MTR_DATA_W'(period_q);
            if (sel_h == SEL_W'(MTR_SEL_COUNT))  rd_data_d = MTR_DATA_W'(count_q);
            for (int i = 0; i < NCHAN; i++) begin
                if (sel_h == SEL_W'(MTR_SEL_CH0 + i)) rd_data_d = MTR_DATA_W'(cnt[i]);
            end
        end
    end

    always_ff @(posedge clk_mtr_h) begin
        if (mr_reset_h) begin
            pia_q      <= '0;
            tbe_q      <= 1'b0;
            ie_q       <= 1'b0;
            oie_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NCHAN; i++) mode_q[i] <= OFF;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            period_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            pia_q      <= pia_d;
            tbe_q      <= tbe_d;
            ie_q       <= ie_d;
            oie_q      <= oie_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            period_q   <= period_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_data_h           = rd_data_q;
    assign rd_valid_h          = rd_valid_q;
    assign tick_h              = tick_q;
    assign mtr_pia_h           = pia_q;
    assign mtr_interrupt_req_h = irq_q;

endmodule

// File: doc/mtr_counter_bank.md
Name: mtr_counter_bank

Overview:
- Parametrised successor to the fixed-function meter board: one prescaled time base, one programmable interval timer and NCHAN general accounting counters.
- Each accounting counter has a selectable qualification mode.
- Sits on the EBUS/diag path. Software programs it and reads it back through a word-select read/write port.
- Raises a level interrupt request at a programmable PI assignment (PIA).

Parameters:
- NCHAN, 4: number of accounting counters, 1..8.
- CNT_W, 36: accounting counter width, 1..36. Reads zero-extend to 36 bits.
- INTVL_W, 12: interval counter and period width, 1..24.
- TICK_DIV, 25: clock cycles per time-base tick, ≥2.
- SEL_W, $clog2(NCHAN+3): word-select width.

Ports:
- clk_mtr_h  in  1  block clock; all state changes on its rising edge
- mr_reset_h  in  1  synchronous active-high reset
- user_mode_h  in  1  processor in user mode this cycle
- ev_h  in  NCHAN  per-channel count-event strobes, sampled every cycle
- wr_stb_h  in  1  one-cycle write strobe
- rd_stb_h  in  1  one-cycle read strobe
- sel_h  in  SEL_W  word select
- wr_data_h  in  36  write data
- rd_data_h  out  36  read data, registered
- rd_valid_h  out  1  read data valid
- tick_h  out  1  one-cycle time-base tick pulse
- mtr_pia_h  out  3  current PI assignment
- mtr_interrupt_req_h  out  1  level interrupt request

Behaviour:
- Word map:
  - sel 0: CTL/STATUS.
  - sel 1: interval period.
  - sel 2: interval count.
  - sel 3+i: channel i counter.
  - Selects above NCHAN+2: reads return 0; writes are ignored.
- CTL field layout:
  - [2:0] PIA.
  - [3] time-base enable (TBE).
  - [4] interval enable (IE).
  - [5] overflow interrupt enable (OIE).
  - [7] interval done (DONE): read status, write-1-to-clear.
  - [8+2i+:2] channel i mode: 00 off, 01 always, 10 user only, 11 exec only.
  - [24+i] channel i overflow flag (OVF_i): write-1-to-clear.
  - All other bits read 0.
- Reset: all registers, flags, counters and the prescaler clear to 0. rd_data_h=0, rd_valid_h=0, tick_h=0, mtr_pia_h=0, mtr_interrupt_req_h=0. Reset has priority over every other event and may occur mid-operation.
- Prescaler:
  - Counts 0..TICK_DIV-1 while TBE=1 and wraps to 0.
  - tick_h pulses for one cycle on the wrap, i.e. every TICK_DIV cycles.
  - TBE=0 holds the prescaler at 0; no ticks.
- Interval timer:
  - Advances on tick_h when IE=1.
  - If period≠0 and count==period-1, count←0 and DONE←1. Otherwise count←count+1, wrapping mod 2^INTVL_W.
  - period=0 never sets DONE.
- Channel i qualification: qualified = ev_h[i] and mode allows (always; user_mode_h=1; user_mode_h=0).
  - Qualified cycle: counter +1.
  - Transition all-ones→0: set OVF_i.
- Simultaneous events:
  - A CPU write to a counter, period or count word wins over an increment in the same cycle.
  - A W1C clear and a flag set in the same cycle: the set wins.
  - A CTL write loads PIA, TBE, IE, OIE and modes, and applies W1C to the flags in the same cycle.
  - A write to the period does not reset the count.
- Read: rd_stb_h in cycle N gives rd_data_h and rd_valid_h=1 in cycle N+1.
  - Data reflects state before any write in cycle N.
  - rd_valid_h is 0 otherwise; rd_data_h holds its last value.
  - Reads have no side effects.
- Interrupt: mtr_interrupt_req_h = (PIA≠0) and (DONE or (OIE and any OVF)), registered with 1-cycle latency.
  - It stays asserted until the causes are cleared or PIA is written to 0.
  - mtr_pia_h = PIA directly.

Decomposition:
- Shared package mtr_pkg holds:
  - select constants MTR_SEL_CTL, MTR_SEL_PERIOD, MTR_SEL_COUNT, MTR_SEL_CH0;
  - CTL bit-position constants;
  - the mode enum mtr_mode_t {OFF, ALWAYS, USER, EXEC}.
- One sub-module, mtr_chan_counter (parameter CNT_W): mode qualify, increment, load, overflow flag with W1C. Instantiated NCHAN times by a generate loop.

Test Plan:
All scenarios use TICK_DIV=4 and NCHAN=4.
1. Reset then read sel 0..6 → every rd_data_h=0 and mtr_interrupt_req_h=0. Hold reset high during active counting → all state is 0 the cycle after.
2. CTL=0x18, period=3 → tick_h every 4th cycle. DONE sets at the 3rd tick and the count returns to 0. With PIA=5 the request asserts one cycle later. Writing CTL with bit 7=1 drops the request the next cycle.
3. Channel 0 mode USER, 10 events with user_mode_h alternating 1/0 → channel 0 reads 5. A channel in mode OFF reads 0.
4. CNT_W=4, channel 1 preloaded 0xF, one qualified event → reads 0, OVF_1 set. With OIE=1 and PIA=2 → request asserts.
5. Write channel 2 with 0x100 in the same cycle as a qualified event → reads 0x100. A W1C of OVF_1 coincident with a new overflow → OVF_1 stays 1.
6. rd_stb_h with sel 7 → rd_data_h=0 and rd_valid_h=1 next cycle. Back-to-back reads give valid data on consecutive cycles.
